// File: rtl/lsu_datapath_pkg.sv
// LSU shared definitions: RV32I width codes, FSM states
// and bus-lane helpers used by decode and the LSU datapath.
package lsu_datapath_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  // Undefined width codes fold into the misaligned path.
  function automatic logic lsu_bad(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic legal;
    logic aligned;
    if (st)
      legal = f3 inside {F3_SB, F3_SH, F3_SW};
    else
      legal = f3 inside {F3_LB, F3_LH, F3_LW,
                         F3_LBU, F3_LHU};
    aligned = (f3[1:0] == 2'b00)
           || (f3[1:0] == 2'b01 && !off[0])
           || (f3[1:0] == 2'b10 && off == 2'b00);
    return !legal || !aligned;
  endfunction

  function automatic logic [3:0] lsu_strb(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [3:0] s;
    unique case (sz)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lsu_lane_data(
    input logic [1:0]  sz,
    input logic [31:0] d
  );
    logic [31:0] r;
    unique case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_datapath_load_extend.sv
// Load lane select and sign/zero extension of the
// returned bus word.
module load_extend
  import lsu_datapath_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [31:0] lane;

  assign lane = word >> {off, 3'b000};

  always_comb begin
    result = lane;
    unique case (f3)
      F3_LB:   result = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   result = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  result = {24'b0, lane[7:0]};
      F3_LHU:  result = {16'b0, lane[15:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/lsu_datapath.sv
// Load/store unit datapath: single outstanding bus access
// with alignment check, lane steering and timeout abort.
module lsu_datapath
  import lsu_datapath_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state, state_nx;
  logic [31:0] cnt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic        st_q, mis_q, berr_q;
  logic        bad, tmo, abort;
  logic [31:0] ext;

  assign bad = lsu_bad(is_store, funct3, addr[1:0]);
  assign tmo = (cnt + 32'd1) == 32'(TIMEOUT);

  // The awaited bus event wins over a coincident timeout.
  assign abort = tmo
              && ((state == ST_REQ && !mem_gnt)
               || (state == ST_WAIT && !mem_rvalid));

  load_extend u_ext (
    .f3     (f3_q),
    .off    (addr_q[1:0]),
    .word   (mem_rdata),
    .result (ext)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (start)
          state_nx = bad ? ST_DONE : ST_REQ;
      ST_REQ:
        if (mem_gnt)
          state_nx = st_q ? ST_DONE : ST_WAIT;
        else if (tmo)
          state_nx = ST_DONE;
      ST_WAIT:
        if (mem_rvalid || tmo)
          state_nx = ST_DONE;
      ST_DONE:
        state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state
          && (state_nx == ST_REQ || state_nx == ST_WAIT))
        cnt <= '0;
      else if (state == ST_REQ || state == ST_WAIT)
        cnt <= cnt + 32'd1;
      else
        cnt <= '0;
      if (state == ST_IDLE && start) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        f3_q    <= funct3;
        st_q    <= is_store;
        mis_q   <= bad;
        berr_q  <= 1'b0;
        rdata_q <= '0;
      end
      if (state == ST_WAIT && mem_rvalid)
        rdata_q <= ext;
      if (abort)
        berr_q <= 1'b1;
    end
  end

  assign busy       = state != ST_IDLE;
  assign done       = state == ST_DONE;
  assign misaligned = done && mis_q;
  assign bus_err    = done && berr_q;
  assign rdata      = (done && !mis_q && !berr_q && !st_q)
                    ? rdata_q : '0;

  assign mem_req   = state == ST_REQ;
  assign mem_we    = mem_req && st_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wstrb = mem_req
                   ? lsu_strb(f3_q[1:0], addr_q[1:0]) : '0;
  assign mem_wdata = mem_we
                   ? lsu_lane_data(f3_q[1:0], wdata_q) : '0;

endmodule

// File: tb/tb_lsu_datapath.sv
// Bench for lsu_datapath: directed table, randomized accesses
// against a reference model, and reset-abandon sequence.
module tb_lsu_datapath;

  localparam int TIMEOUT = 16;

  typedef struct {
    int          lat;
    bit          mis;
    bit          berr;
    bit [31:0]   rdata;
    int          nreq;
    bit [3:0]    strb;
    bit [31:0]   wd;
  } exp_t;

  typedef struct {
    bit          st;
    bit [2:0]    f3;
    bit [31:0]   a;
    bit [31:0]   wd;
    bit [31:0]   word;
    int          gd;
    int          rd;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, misaligned, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  int          o_lat, o_nreq;
  logic [31:0] o_rdata, o_addr, o_wd;
  logic        o_mis, o_berr, o_we, o_inv, o_busy_bad;
  logic [3:0]  o_strb;

  always #5 clk = ~clk;

  lsu_datapath #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  // Reference: derived from access width and byte offset.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int size, off;
    bit legal, sgn;
    longint unsigned m, x;
    e = '{default: 0};
    if (v.st) legal = v.f3 <= 3'd2;
    else legal = v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    size = 1 << v.f3[1:0];
    sgn = !v.f3[2];
    off = int'(v.a[1:0]);
    e.mis = !legal || (off % size != 0);
    if (e.mis) begin
      e.lat = 1;
      return e;
    end
    e.nreq = (v.gd >= TIMEOUT) ? TIMEOUT : v.gd + 1;
    for (int i = 0; i < 4; i++) begin
      e.strb[i] = (i >= off) && (i < off + size);
      e.wd[8*i +: 8] = v.wd[8*(i % size) +: 8];
    end
    if (v.gd >= TIMEOUT) begin
      e.berr = 1;
      e.lat = TIMEOUT + 1;
    end else if (v.st) begin
      e.lat = v.gd + 2;
    end else if (v.rd >= TIMEOUT) begin
      e.berr = 1;
      e.lat = v.gd + TIMEOUT + 2;
    end else begin
      e.lat = v.gd + v.rd + 3;
      m = (64'd1 << (8 * size)) - 64'd1;
      x = (64'(v.word) >> (8 * off)) & m;
      if (sgn && size < 4 && x > (m >> 1))
        x = x - (m + 64'd1);
      e.rdata = x[31:0];
    end
    return e;
  endfunction

  // Drives one access from IDLE and plays the memory side.
  task automatic do_access(input vec_t v);
    int rq, wt;
    bit granted;
    start = 1; is_store = v.st; funct3 = v.f3;
    addr = v.a; wdata = v.wd;
    mem_gnt = 0; mem_rvalid = 0;
    o_lat = -1; o_rdata = '1; o_mis = 1; o_berr = 1;
    o_addr = '1; o_we = 1; o_strb = '1; o_wd = '1;
    o_inv = 0; o_busy_bad = busy;
    rq = 0; wt = 0; granted = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (!mem_req && (mem_we || mem_addr != 0
          || mem_wstrb != 0 || mem_wdata != 0)) o_inv = 1;
      if (!done && (misaligned || bus_err || rdata != 0))
        o_inv = 1;
      if (misaligned && bus_err) o_inv = 1;
      if (!busy) o_busy_bad = 1;
      if (done) begin
        o_lat = n; o_rdata = rdata;
        o_mis = misaligned; o_berr = bus_err;
        break;
      end
      start = 1'($urandom_range(0, 1));
      is_store = 1'($urandom_range(0, 1));
      funct3 = 3'($urandom_range(0, 7));
      addr = $urandom; wdata = $urandom;
      if (granted) begin
        if (wt == v.rd) begin
          mem_rvalid = 1; mem_rdata = v.word;
        end else begin
          mem_gnt = 1'($urandom_range(0, 1));
        end
        wt++;
      end else if (mem_req) begin
        if (rq == 0) begin
          o_addr = mem_addr; o_we = mem_we;
          o_strb = mem_wstrb; o_wd = mem_wdata;
        end
        mem_gnt = (rq == v.gd);
        mem_rvalid = 1'($urandom_range(0, 1));
        granted = mem_gnt && !v.st;
        rq++;
      end
    end
    start = 0; mem_gnt = 0; mem_rvalid = 0;
    o_nreq = rq;
  endtask

  task automatic run_vec(input string tag, input vec_t v,
                         input exp_t e);
    do_access(v);
    chk({tag, ".lat"}, 32'(o_lat), 32'(e.lat));
    chk({tag, ".mis"}, 32'(o_mis), 32'(e.mis));
    chk({tag, ".berr"}, 32'(o_berr), 32'(e.berr));
    chk({tag, ".rdata"}, o_rdata, e.rdata);
    chk({tag, ".nreq"}, 32'(o_nreq), 32'(e.nreq));
    chk({tag, ".idle_outs"}, 32'(o_inv), 0);
    chk({tag, ".busy"}, 32'(o_busy_bad), 0);
    if (e.nreq > 0) begin
      chk({tag, ".maddr"}, o_addr, {v.a[31:2], 2'b00});
      chk({tag, ".we"}, 32'(o_we), 32'(v.st));
      if (v.st) begin
        chk({tag, ".wstrb"}, 32'(o_strb), 32'(e.strb));
        chk({tag, ".wdata"}, o_wd, e.wd);
      end
    end
    @(posedge clk); #1;
    chk({tag, ".post"}, {30'b0, busy, done}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ctl"},
        {22'b0, busy, done, misaligned, bus_err,
         mem_req, mem_we, mem_wstrb}, 0);
    chk({tag, ".rdata"}, rdata, 0);
    chk({tag, ".maddr"}, mem_addr, 0);
    chk({tag, ".mwdata"}, mem_wdata, 0);
  endtask

  vec_t tbl[$];
  vec_t v;
  bit   seen;
  int   r;

  initial begin
    tbl.push_back('{1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0,
      '{2, 0, 0, 32'h0, 1, 4'hF, 32'hDEADBEEF}});
    tbl.push_back('{1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0,
      '{2, 0, 0, 32'h0, 1, 4'h8, 32'hA5A5A5A5}});
    tbl.push_back('{1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0,
      '{2, 0, 0, 32'h0, 1, 4'hC, 32'hABCDABCD}});
    tbl.push_back('{0, 3'b000, 32'h202, 0, 32'h12F03456, 0, 0,
      '{3, 0, 0, 32'hFFFFFFF0, 1, 0, 0}});
    tbl.push_back('{0, 3'b100, 32'h202, 0, 32'h12F03456, 0, 0,
      '{3, 0, 0, 32'h000000F0, 1, 0, 0}});
    tbl.push_back('{0, 3'b001, 32'h206, 0, 32'h80017FFF, 0, 0,
      '{3, 0, 0, 32'hFFFF8001, 1, 0, 0}});
    tbl.push_back('{0, 3'b101, 32'h204, 0, 32'h80017FFF, 1, 2,
      '{6, 0, 0, 32'h00007FFF, 2, 0, 0}});
    tbl.push_back('{0, 3'b010, 32'h400, 0, 32'hCAFEF00D, 2, 3,
      '{8, 0, 0, 32'hCAFEF00D, 3, 0, 0}});
    tbl.push_back('{0, 3'b001, 32'h201, 0, 32'h11111111, 0, 0,
      '{1, 1, 0, 32'h0, 0, 0, 0}});
    tbl.push_back('{1, 3'b010, 32'h102, 32'h55, 0, 0, 0,
      '{1, 1, 0, 32'h0, 0, 0, 0}});
    tbl.push_back('{1, 3'b100, 32'h100, 32'h55, 0, 0, 0,
      '{1, 1, 0, 32'h0, 0, 0, 0}});
    tbl.push_back('{0, 3'b011, 32'h100, 0, 32'h22222222, 0, 0,
      '{1, 1, 0, 32'h0, 0, 0, 0}});
    tbl.push_back('{0, 3'b010, 32'h300, 0, 32'h33333333, 16, 0,
      '{17, 0, 1, 32'h0, 16, 0, 0}});
    tbl.push_back('{0, 3'b010, 32'h300, 0, 32'h44444444, 0, 16,
      '{18, 0, 1, 32'h0, 1, 0, 0}});
    tbl.push_back('{1, 3'b010, 32'h010, 32'h01234567, 0, 15, 0,
      '{17, 0, 0, 32'h0, 16, 4'hF, 32'h01234567}});
    tbl.push_back('{0, 3'b000, 32'h301, 0, 32'h00007F00, 0, 0,
      '{3, 0, 0, 32'h0000007F, 1, 0, 0}});

    rst_n = 0; start = 0; is_store = 0; funct3 = 0;
    addr = 0; wdata = 0; mem_gnt = 0; mem_rvalid = 0;
    mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;

    foreach (tbl[i])
      run_vec($sformatf("tbl%0d", i), tbl[i], tbl[i].e);

    // Reset while waiting for read data abandons the access.
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk); #1;
    start = 0;
    chk("rstw.req", 32'(mem_req), 1);
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    chk("rstw.wait", {30'b0, mem_req, busy}, 32'b01);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    mem_rvalid = 1; mem_rdata = 32'h99999999;
    chk_zero("rstw.after");
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      mem_rvalid = 0;
      if (done || busy) seen = 1;
    end
    chk("rstw.no_done", 32'(seen), 0);
    v = '{0, 3'b010, 32'h504, 0, 32'h0BADF00D, 1, 1,
          '{0, 0, 0, 0, 0, 0, 0}};
    run_vec("rstw.lw", v, model(v));

    for (int i = 0; i < 60; i++) begin
      v.st = 1'($urandom_range(0, 1));
      v.f3 = 3'($urandom_range(0, 7));
      v.a = $urandom;
      v.wd = $urandom;
      v.word = $urandom;
      r = $urandom_range(0, 9);
      v.gd = (r < 7) ? r % 3 : (r == 7 ? 15 : 8 + r);
      r = $urandom_range(0, 9);
      v.rd = (r < 7) ? r % 3 : (r == 7 ? 15 : 8 + r);
      run_vec($sformatf("rnd%0d", i), v, model(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_datapath.md
LSU_DATAPATH -- requirements
Module: lsu_datapath

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles waited for mem_gnt or mem_rvalid before the access aborts with bus error.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 start  in  1  one-cycle request to begin an access; sampled only in IDLE.
REQ-005 is_store  in  1  1 = store, 0 = load; sampled with start.
REQ-006 funct3  in  3  RV32I width code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
REQ-007 addr  in  32  effective byte address, i.e. the ALU ADD result; sampled with start.
REQ-008 wdata  in  32  store data (rs2); sampled with start.
REQ-009 busy  out  1  high from the cycle after start until done.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rdata  out  32  extended load result; valid while done=1.
REQ-012 misaligned  out  1  address misaligned for width; valid while done=1.
REQ-013 bus_err  out  1  timeout abort; valid while done=1.
REQ-014 mem_req  out  1  bus request; held until mem_gnt.
REQ-015 mem_we  out  1  bus write enable.
REQ-016 mem_addr  out  32  word address: addr[31:2] followed by 2'b00.
REQ-017 mem_wstrb  out  4  byte enables.
REQ-018 mem_wdata  out  32  store data replicated into lane: byte x4, half x2, word.
REQ-019 mem_gnt  in  1  bus accepts request this cycle.
REQ-020 mem_rvalid  in  1  read data valid; earliest one cycle after mem_gnt.
REQ-021 mem_rdata  in  32  read word.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: start moves to REQ, or to DONE if misaligned.
- REQ: mem_gnt moves to DONE for stores, WAIT for loads.
- WAIT: mem_rvalid moves to DONE.
- DONE: always returns to IDLE.
REQ-023 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Result: no mem_req, misaligned=1, rdata=0, done one cycle after start.
REQ-024 Undefined funct3 (011, 110, 111, or 1xx on store) is treated as misaligned.
REQ-025 Byte strobe = 4'b0001 << addr[1:0]. Half strobe = 4'b0011 << addr[1:0]. Word strobe = 4'b1111.
REQ-026 Loads: lane = mem_rdata >> (8*addr[1:0]), captured in the rvalid cycle. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-027 Minimum latency with mem_gnt in the first REQ cycle:
- store: done 2 cycles after start.
- load with rvalid one cycle after gnt: done 3 cycles after start.
REQ-028 A 32-bit cycle counter clears on entry to REQ and WAIT. When it reaches TIMEOUT in either state: mem_req drops, state goes to DONE, bus_err=1, rdata=0.
REQ-029 start while busy is ignored; no queuing.
REQ-030 mem_rvalid or mem_gnt outside the state expecting it is ignored.
REQ-031 done, misaligned and bus_err are mutually consistent: at most one of misaligned/bus_err is high, and only while done=1; otherwise all are 0.
REQ-032 mem_we, mem_addr, mem_wstrb and mem_wdata are 0 whenever mem_req=0.

Reset
REQ-033 When rst_n=0 at a clock edge:
- state goes to IDLE.
- all outputs go to 0, including mem_req, busy, done and rdata.
- the counter goes to 0.
REQ-034 Reset mid-access abandons the access and emits no done pulse; the memory side must tolerate a dropped request.

Structure
REQ-035 The shared package holds:
- funct3 width codes (LB..LHU, SB..SW), shared with decode.
- FSM state enum.
- TIMEOUT default.
REQ-036 Sub-module load_extend: combinational lane select plus sign/zero extension from funct3, addr[1:0] and mem_rdata.

Verification
REQ-037 SW with addr=0x100, wdata=0xDEADBEEF, gnt in first REQ cycle -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, done 2 cycles after start.
REQ-038 SB with addr=0x103, wdata=0x000000A5 -> wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
REQ-039 LB with addr=0x202, mem_rdata=0x12F03456 -> rdata=0xFFFFFFF0. Same access as LBU -> rdata=0x000000F0.
REQ-040 LH with addr=0x201 -> no mem_req, done next cycle, misaligned=1.
REQ-041 LW with mem_gnt held low for TIMEOUT cycles -> bus_err=1 with done, mem_req drops, busy clears the following cycle.
REQ-042 rst_n low while in WAIT -> IDLE next cycle, all outputs 0, no done. A subsequent LW then completes normally.
